// File: rtl/isram_axi_rd_bridge.sv
// Instruction-fetch SRAM-like request port to single-beat AXI4 read bridge.
// One AR at a time, up to MAX_OUTSTANDING reads in flight, in-order return.
module isram_axi_rd_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [3:0]  AXI_ID          = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned   CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;

  ar_state_t     state;
  logic [CW-1:0] cnt;
  logic          unused;

  assign unused = ^{rid, rresp, inst_sram_wstrb, inst_sram_wdata};

  assign arid    = AXI_ID;
  assign arlen   = '0;
  assign arburst = 2'b01;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;

  assign inst_sram_addr_ok = resetn & (state == AR_IDLE) & inst_sram_req &
                             ~inst_sram_wr & (cnt < CNT_MAX);
  assign rready            = resetn;
  assign inst_sram_data_ok = rvalid & rready & rlast;
  assign inst_sram_rdata   = rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= AR_IDLE;
      arvalid <= 1'b0;
      araddr  <= '0;
      arsize  <= 3'b010;
      cnt     <= '0;
    end else begin
      case (state)
        AR_IDLE: if (inst_sram_addr_ok) begin
          state   <= AR_SEND;
          arvalid <= 1'b1;
          araddr  <= inst_sram_addr;
          arsize  <= {1'b0, inst_sram_size};
        end
        AR_SEND: if (arready) begin
          state   <= AR_IDLE;
          arvalid <= 1'b0;
        end
        default: begin
          state   <= AR_IDLE;
          arvalid <= 1'b0;
        end
      endcase
      // A stray R beat with nothing outstanding leaves cnt at zero.
      case ({inst_sram_addr_ok, inst_sram_data_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   if (cnt != '0) cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
